lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Upstream command feeder for the LCD image controller. Buffers a command script pushed by the
//  testbench/host in a small FIFO. Issues each command on cmd/cmd_valid only when the controller is
//  idle (busy low), and holds cmd stable for the whole execution. After issuing WRITE (cmd 0) it
//  halts, waits for the controller's done, and then reports sequence completion.
// PARAMETERS
//  FIFO_DEPTH  8  command FIFO entries (power of 2, >=2)
//  ACK_TO      4  cycles to wait for busy to rise after an issue before treating the command as complete
//  CNT_W       8  width of issued-command counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  reset       in   1      reset, asynchronous, active-low
//  in_cmd      in   3      command to enqueue (0 write, 1 up, 2 down, 3 left, 4 right, 5 max, 6 min, 7 avg)
//  in_valid    in   1      in_cmd valid
//  in_ready    out  1      FIFO can accept; push = in_valid & in_ready
//  busy        in   1      controller busy
//  done        in   1      controller finished write-back
//  cmd         out  3      command to controller, held until next issue
//  cmd_valid   out  1      one-cycle issue strobe
//  issued_cnt  out  CNT_W  number of commands issued, saturates at all-ones
//  fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
//  seq_done    out  1      sticky: WRITE issued and done seen
// BEHAVIOUR
//  Reset (reset==0, async): FIFO empty, state IDLE, cmd=0, cmd_valid=0, issued_cnt=0, seq_done=0,
//   in_ready=0 while reset is asserted, then 1. All outputs are registered except in_ready and fifo_level (from count).
//  FIFO: in_ready = !full && state!=HALT. Push and pop in the same cycle leave the count unchanged.
//   When full, push is blocked even if a pop occurs that cycle. Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, HALT.
//   IDLE: go to ISSUE when fifo not empty and busy==0.
//   ISSUE (1 cycle): pop head. Register cmd<=head, cmd_valid<=1 for exactly this one cycle.
//    issued_cnt+1 (saturating). Go to WAIT_HI. Clear the timeout counter.
//   WAIT_HI: busy==1 -> WAIT_LO. Otherwise increment the timeout counter.
//    After ACK_TO cycles without busy, treat the command as complete: go to IDLE, or to HALT if cmd==0.
//   WAIT_LO: busy==0 -> IDLE, or HALT if cmd==0.
//   HALT: no further issue. FIFO contents are retained but frozen, and in_ready=0.
//    First cycle done==1 -> seq_done<=1 (sticky). Only reset leaves HALT.
//  Issue latency: command at FIFO head with busy low -> cmd_valid high 2 cycles later (IDLE->ISSUE->strobe).
//  cmd is never changed outside ISSUE. The controller samples cmd during execution, so it must be stable.
//  busy high in IDLE: wait and do not issue. done asserted outside HALT: ignored.
//  in_valid while in HALT: not accepted (in_ready=0) and no error.
//  Reset mid-operation: everything returns to reset values immediately. Queued commands are lost.
// TESTING
//  1 Push 2,4,0 with busy low and busy pulsed high 3 cycles after each strobe
//    -> three cmd_valid pulses, cmd=2,4,0 in order, issued_cnt=3.
//    Then done=1 -> seq_done=1 next cycle, in_ready=0.
//  2 Push FIFO_DEPTH+1 commands while busy held high -> in_ready=0 after 8 pushes,
//    fifo_level=8, no cmd_valid.
//    Release busy -> commands drain in push order.
//  3 Issue cmd 1 and keep busy low -> return to IDLE after ACK_TO=4 cycles.
//    The next queued command then issues. cmd holds 1 throughout the wait.
//  4 Push 7 then 5 with busy held high for 10 cycles after each strobe
//    -> second strobe no earlier than 2 cycles after busy falls. cmd=7 is stable for all 10 busy cycles.
//  5 Assert reset in WAIT_LO with 3 queued commands -> cmd_valid=0, fifo_level=0,
//    issued_cnt=0, cmd=0 asynchronously (before the next clk edge).
//  6 Push 0 then 3 -> only 0 is issued. FSM enters HALT, 3 stays unissued, and in_ready=0 until reset.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Feeds a buffered command script to the LCD image controller one command at
// a time. Commands are queued in a small FIFO. Each one is issued with a single
// cmd_valid strobe, but only when the controller is idle. cmd is then held
// steady while the controller executes it. A WRITE command (0) ends the
// script. The sequencer halts and waits for the controller's done before it
// flags seq_done.

module lcd_cmd_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ACK_TO     = 4,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [2:0]                    in_cmd,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          busy,
   input  logic                          done,
   output logic [2:0]                    cmd,
   output logic                          cmd_valid,
   output logic [CNT_W-1:0]              issued_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          seq_done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMO_W = $clog2(ACK_TO + 1);

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TO - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [2:0]       CMD_WRITE  = 3'd0;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      HALT
   } state_t;

   state_t            state;

   logic [2:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [2:0]        head;

   // FIFO status and handshake. in_ready is held low during reset and for
   // the whole HALT state, so the script stays frozen once WRITE has gone out.
   assign fifo_full  = (count == FULL_COUNT);
   assign fifo_empty = (count == '0);
   assign in_ready   = reset && !fifo_full && (state != HALT);
   assign push       = in_valid && in_ready;
   assign pop        = (state == ISSUE) && !fifo_empty;
   assign head       = fifo_mem[rd_ptr];
   assign fifo_level = count;

   // Command storage. It needs no reset because count decides which
   // entries hold valid data.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_cmd;
      end
   end

   // FIFO pointers and occupancy. The pointers wrap naturally because the
   // depth is a power of two. A push and a pop in the same cycle cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Issue FSM with registered outputs. A command leaves the FIFO in ISSUE.
   // The FSM then waits for the controller to acknowledge it with busy and
   // to finish, or it gives up on the acknowledge after ACK_TO quiet cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cmd        <= '0;
         cmd_valid  <= 1'b0;
         issued_cnt <= '0;
         seq_done   <= 1'b0;
         tmo_cnt    <= '0;
      end else begin
         cmd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty && !busy) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               cmd       <= head;
               cmd_valid <= 1'b1;
               if (issued_cnt != CNT_MAX) begin
                  issued_cnt <= issued_cnt + 1'b1;
               end
               tmo_cnt <= '0;
               state   <= WAIT_HI;
            end
            WAIT_HI: begin
               if (busy) begin
                  state <= WAIT_LO;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= (cmd == CMD_WRITE) ? HALT : IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!busy) begin
                  state <= (cmd == CMD_WRITE) ? HALT : IDLE;
               end
            end
            HALT: begin
               if (done) begin
                  seq_done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer
// Self-checking bench for lcd_cmd_sequencer. A transaction-level reference
// model tracks the queued script and the time of each strobe. Directed
// scenarios, a cycle table and randomized traffic all run against that model.

module tb_lcd_cmd_sequencer;

   localparam int DEPTH = 8;
   localparam int ACK   = 4;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    in_cmd;
   logic          in_valid;
   logic          in_ready;
   logic          busy;
   logic          done;
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic [CW-1:0] issued_cnt;
   logic [3:0]    fifo_level;
   logic          seq_done;

   lcd_cmd_sequencer #(
      .FIFO_DEPTH (DEPTH),
      .ACK_TO     (ACK),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_cmd     (in_cmd),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .busy       (busy),
      .done       (done),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .issued_cnt (issued_cnt),
      .fifo_level (fifo_level),
      .seq_done   (seq_done)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   int checksTotal;
   int checksPassed;

   // Reference model state: the queued script, plus timestamps of the
   // pending issue and of the last strobe
   int q[$];
   int cyc;
   int issueAt;
   int strobeAt;
   bit inflight;
   bit ackSeen;
   bit halted;
   bit mSeqDone;
   int lastCmd;
   int mCnt;
   bit expValid;

   // Strobes seen on the DUT: the command and the cycle of each
   int obsCmd[$];
   int obsCyc[$];

   typedef struct {
      bit v;
      int c;
      bit b;
      bit d;
      bit eValid;
      int eCmd;
      int eCnt;
      int eLevel;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input int got, input int exp);
      checksTotal++;
      if (got == exp) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic modelReset();
      q.delete();
      cyc      = 0;
      issueAt  = -1;
      strobeAt = -1;
      inflight = 1'b0;
      ackSeen  = 1'b0;
      halted   = 1'b0;
      mSeqDone = 1'b0;
      lastCmd  = 0;
      mCnt     = 0;
      expValid = 1'b0;
      obsCmd.delete();
      obsCyc.delete();
   endtask

   // Assert reset partway through a cycle. Check that the outputs clear
   // before any clock edge, then release the reset on a falling edge.
   task automatic doReset();
      #3;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_cmd   = 3'd0;
      busy     = 1'b0;
      done     = 1'b0;
      #1;
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_issued_cnt", issued_cnt, 0);
      check("rst_cmd", cmd, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_seq_done", seq_done, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      modelReset();
      #1;
   endtask

   task automatic checkOutput();
      check("cmd_valid", cmd_valid, expValid);
      check("cmd", cmd, lastCmd);
      check("issued_cnt", issued_cnt, mCnt);
      check("seq_done", seq_done, mSeqDone);
      if (cmd_valid) begin
         obsCmd.push_back(int'(cmd));
         obsCyc.push_back(cyc);
      end
   endtask

   // Drive one cycle of inputs and check in_ready and fifo_level for this
   // cycle. Then advance the model and check the registered outputs after
   // the clock edge.
   task automatic applyStimulus(input bit v, input int c, input bit b, input bit d);
      bit expReady;
      bit finish;
      int preSize;
      in_valid = v;
      in_cmd   = c[2:0];
      busy     = b;
      done     = d;
      expReady = (q.size() < DEPTH) && !halted;
      check("in_ready", in_ready, expReady);
      check("fifo_level", fifo_level, q.size());
      preSize  = q.size();
      finish   = 1'b0;
      expValid = 1'b0;
      if (halted && d) begin
         mSeqDone = 1'b1;
      end
      if (issueAt == cyc) begin
         lastCmd  = q.pop_front();
         expValid = 1'b1;
         if (mCnt < (1 << CW) - 1) begin
            mCnt++;
         end
         inflight = 1'b1;
         ackSeen  = 1'b0;
         strobeAt = cyc + 1;
         issueAt  = -1;
      end else if (inflight) begin
         if (!ackSeen) begin
            if (b) begin
               ackSeen = 1'b1;
            end else if (cyc - strobeAt == ACK - 1) begin
               finish = 1'b1;
            end
         end else if (!b) begin
            finish = 1'b1;
         end
      end else if (!halted && preSize > 0 && !b) begin
         issueAt = cyc + 1;
      end
      if (finish) begin
         inflight = 1'b0;
         if (lastCmd == 0) begin
            halted = 1'b1;
         end
      end
      if (v && expReady) begin
         q.push_back(c & 7);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      checkOutput();
   endtask

   // Controller model: busy goes high dly cycles after the last strobe and
   // stays high for len cycles
   function automatic bit ctrlBusy(input int dly, input int len);
      return (strobeAt >= 0) && (cyc >= strobeAt + dly) && (cyc < strobeAt + dly + len);
   endfunction

   task automatic runCtrl(input int n, input int dly, input int len);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 0, ctrlBusy(dly, len), 1'b0);
      end
   endtask

   task automatic setVec(input int i, input bit v, input int c, input bit b, input bit d,
                         input bit ev, input int ec, input int ecnt, input int el);
      tbl[i].v      = v;
      tbl[i].c      = c;
      tbl[i].b      = b;
      tbl[i].d      = d;
      tbl[i].eValid = ev;
      tbl[i].eCmd   = ec;
      tbl[i].eCnt   = ecnt;
      tbl[i].eLevel = el;
   endtask

   initial begin
      int exp2[8];
      bit busyReg;
      int c;
      checksTotal  = 0;
      checksPassed = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_cmd   = 3'd0;
      busy     = 1'b0;
      done     = 1'b0;
      busyReg  = 1'b0;
      modelReset();

      // Ack-timeout cycle table: push 1 then 6 with busy low throughout.
      // Columns: inputs v,c,b,d, then cmd_valid, cmd, issued_cnt and
      // fifo_level after the edge.
      setVec(0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1);
      setVec(1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 0, 0, 2);
      setVec(2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1, 1);
      setVec(3, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 1);
      setVec(4, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 1);
      setVec(5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 1);
      setVec(6, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 1);
      setVec(7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 1);
      setVec(8, 1'b0, 0, 1'b0, 1'b0, 1'b1, 6, 2, 0);
      setVec(9, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6, 2, 0);

      @(negedge clk);
      doReset();

      $display("[TB] scenario: script 2,4,0 with short busy pulses");
      applyStimulus(1'b1, 2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4, 1'b0, 1'b0);
      applyStimulus(1'b1, 0, 1'b0, 1'b0);
      runCtrl(40, 3, 1);
      check("s1_strobes", obsCmd.size(), 3);
      check("s1_cmd0", obsCmd[0], 2);
      check("s1_cmd1", obsCmd[1], 4);
      check("s1_cmd2", obsCmd[2], 0);
      check("s1_gap", obsCyc[1] - obsCyc[0], 7);
      check("s1_cnt", issued_cnt, 3);
      check("s1_seq_done_pre", seq_done, 0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      check("s1_seq_done", seq_done, 1);
      check("s1_in_ready", in_ready, 0);

      $display("[TB] scenario: overfill while busy, then drain");
      doReset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus(1'b1, (i % 7) + 1, 1'b1, 1'b0);
      end
      check("s2_level", fifo_level, 8);
      check("s2_in_ready", in_ready, 0);
      check("s2_no_strobe", obsCmd.size(), 0);
      runCtrl(90, 1, 2);
      exp2 = '{1, 2, 3, 4, 5, 6, 7, 1};
      check("s2_strobes", obsCmd.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("s2_order", obsCmd[i], exp2[i]);
      end

      $display("[TB] scenario: ack timeout table");
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].d);
         check("tbl_cmd_valid", cmd_valid, tbl[i].eValid);
         check("tbl_cmd", cmd, tbl[i].eCmd);
         check("tbl_issued_cnt", issued_cnt, tbl[i].eCnt);
         check("tbl_fifo_level", fifo_level, tbl[i].eLevel);
      end

      $display("[TB] scenario: long busy holds cmd");
      doReset();
      applyStimulus(1'b1, 7, 1'b0, 1'b0);
      applyStimulus(1'b1, 5, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         bit b;
         b = ctrlBusy(1, 10);
         applyStimulus(1'b0, 0, b, 1'b0);
         if (b && obsCmd.size() == 1) begin
            check("s4_cmd_hold", cmd, 7);
         end
      end
      check("s4_strobes", obsCmd.size(), 2);
      check("s4_cmd1", obsCmd[1], 5);
      check("s4_gap", obsCyc[1] - obsCyc[0], 14);

      $display("[TB] scenario: reset while waiting for busy to fall");
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 3 + i, ctrlBusy(1, 50), 1'b0);
      end
      runCtrl(4, 1, 50);
      check("s5_level", fifo_level, 3);
      check("s5_cmd", cmd, 3);
      check("s5_cnt", issued_cnt, 1);
      doReset();

      $display("[TB] scenario: WRITE halts the script");
      applyStimulus(1'b1, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3, 1'b0, 1'b0);
      runCtrl(20, 100, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6, 1'b0, 1'b0);
      end
      check("s6_strobes", obsCmd.size(), 1);
      check("s6_cmd", obsCmd[0], 0);
      check("s6_level", fifo_level, 1);
      check("s6_in_ready", in_ready, 0);
      check("s6_seq_done_pre", seq_done, 0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      check("s6_seq_done_sticky", seq_done, 1);
      check("s6_level_frozen", fifo_level, 1);

      $display("[TB] scenario: issued_cnt saturation");
      doReset();
      for (int i = 0; i < 1700; i++) begin
         applyStimulus(q.size() < 2, (i % 7) + 1, 1'b0, 1'b0);
      end
      check("sat_cnt", issued_cnt, 255);

      $display("[TB] scenario: randomized traffic");
      for (int r = 0; r < 5; r++) begin
         doReset();
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               busyReg = !busyReg;
            end
            c = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(1, 7));
            applyStimulus(1'($urandom_range(0, 1)), c, busyReg, ($urandom_range(0, 7) == 0));
         end
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
